seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational ALU.
- Generalises datapath width and adds iterative multi-cycle multiply and unsigned divide behind a start/ready/done handshake.
- Produces status flags (zero, carry, overflow, div-by-zero, illegal op).
- Sits between register-file read and writeback; the core stalls issue while ready is low.

Parameters:
- WIDTH, 16, datapath width in bits; power of two, minimum 4.
- OP_WIDTH, 4, opcode width.
- SHW, $clog2(WIDTH), derived shift-amount width; not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when ready=1.
- op  in  OP_WIDTH  operation code, sampled on accept.
- reg1  in  WIDTH  operand A, sampled on accept.
- reg2  in  WIDTH  operand B / shift amount, sampled on accept.
- ready  out  1  able to accept start this cycle.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- regOut  out  WIDTH  result low word.
- regOutHi  out  WIDTH  MUL high word / DIVU remainder; 0 for other ops.
- flagZero  out  1  regOut==0.
- flagCarry  out  1  ADD carry-out, SUB borrow; 0 otherwise.
- flagOvf  out  1  signed overflow for ADD/SUB; 0 otherwise.
- flagDivZero  out  1  DIVU with reg2==0.
- flagIllegal  out  1  unknown opcode.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR.
  - 5 SL, 6 SR (logical), 7 SRA (arithmetic); shift amount is reg2[SHW-1:0], upper bits ignored.
  - 8 MUL, unsigned, 2*WIDTH product split as {regOutHi, regOut}.
  - 9 DIVU: quotient to regOut, remainder to regOutHi.
  - 10..max are illegal: regOut=0, regOutHi=0, flagIllegal=1, completed as a single-cycle op.
- Reset (async, rst_n=0):
  - state=IDLE, ready=1, done=0; all result and flag outputs 0; iteration counter 0.
  - Reset mid-operation abandons the operation; no done is issued afterwards.
- States: IDLE, BUSY.
- IDLE: ready=1. On start=1 at a clock edge, op/reg1/reg2 are latched.
  - Single-cycle ops (0-7, illegal): result and flags registered at that edge; done=1 for the following cycle; state stays IDLE. ready stays 1, so back-to-back issue every cycle is legal, giving one done per accept.
  - MUL/DIVU: state to BUSY, counter=0, ready=0 from the next cycle.
  - DIVU with reg2==0: completes as a single-cycle op with regOut=all ones, regOutHi=reg1, flagDivZero=1.
- BUSY: one iteration per cycle.
  - MUL is shift-add, LSB first.
  - DIVU is restoring, MSB first.
  - Counter runs 0..WIDTH-1. The edge completing iteration WIDTH-1 registers the outputs and returns to IDLE; done=1 and ready=1 during that next cycle.
  - Latency from accept edge to done cycle: 1 cycle for single-cycle ops, WIDTH cycles for MUL/DIVU.
  - start while ready=0 is ignored (not queued).
  - A start in the done cycle is accepted normally.
- Output hold: regOut, regOutHi and flags hold their last values until the next completion. They do not change during BUSY. done is deasserted in every cycle other than the completion-following cycle.
- Arithmetic:
  - All results are truncated to WIDTH.
  - flagCarry for ADD = bit WIDTH of A+B; for SUB = (A<B unsigned).
  - flagOvf for ADD = sign(A)==sign(B) and sign(result)!=sign(A); for SUB = sign(A)!=sign(B) and sign(result)!=sign(A).
  - flagZero evaluates regOut only, for every op including illegal (illegal gives flagZero=1).
  - Each completion sets every flag afresh; flags not defined for an op are 0.

Test Plan:
- WIDTH=16. Reset asserted mid-cycle with no clock edge -> all outputs 0 and ready=1 immediately. Release, then ADD reg1=2, reg2=3 -> next cycle done=1, regOut=5, flagZero=0, flagCarry=0.
- ADD 0xFFFF+0x0001 -> regOut=0, flagZero=1, flagCarry=1, flagOvf=0. ADD 0x7FFF+1 -> 0x8000, flagOvf=1. SUB 3-5 -> 0xFFFE, flagCarry=1.
- SL 0x0002 by reg2=0x0015 (amount 5) -> 0x0040. SRA 0x8000 by 15 -> 0xFFFF. SR 0x8000 by 15 -> 0x0001.
- MUL 0x1234*0x5678 -> ready low for exactly 15 cycles after the accept edge; done 16 cycles after accept; regOutHi=0x0626, regOut=0x0060. A start pulsed mid-BUSY is ignored, so exactly one done.
- DIVU 100/7 -> regOut=14, regOutHi=2, done after 16 cycles. DIVU 0x1234/0 -> 1-cycle done, regOut=0xFFFF, regOutHi=0x1234, flagDivZero=1.
- Back-to-back ADD, XOR, opcode 12 on consecutive cycles -> three consecutive done pulses with correct results; the third has flagIllegal=1 and regOut=0. MUL with rst_n pulsed low at iteration 8 -> outputs 0, no done, ready=1.

Source files
------------

// File: rtl/seq_alu_if.sv
// Issue/complete bus of the sequential ALU: request operands in, result and flags out.
interface seq_alu_if #(
   parameter int WIDTH    = 16,
   parameter int OP_WIDTH = 4
);
   logic                start;
   logic [OP_WIDTH-1:0] op;
   logic [WIDTH-1:0]    reg1;
   logic [WIDTH-1:0]    reg2;
   logic                ready;
   logic                done;
   logic [WIDTH-1:0]    regOut;
   logic [WIDTH-1:0]    regOutHi;
   logic                flagZero;
   logic                flagCarry;
   logic                flagOvf;
   logic                flagDivZero;
   logic                flagIllegal;

   modport master (
      output start, op, reg1, reg2,
      input  ready, done, regOut, regOutHi,
      input  flagZero, flagCarry, flagOvf, flagDivZero, flagIllegal
   );

   modport slave (
      input  start, op, reg1, reg2,
      output ready, done, regOut, regOutHi,
      output flagZero, flagCarry, flagOvf, flagDivZero, flagIllegal
   );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with single-cycle logic/arith/shift ops and iterative
// shift-add MUL / restoring DIVU behind a start/ready/done handshake.
module seq_alu #(
   parameter int WIDTH    = 16,
   parameter int OP_WIDTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   seq_alu_if.slave    bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] OP_SL   = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] OP_SR   = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(7);
   localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(8);
   localparam logic [OP_WIDTH-1:0] OP_DIVU = OP_WIDTH'(9);

   // flag vector bit positions
   localparam int F_ZERO = 0;
   localparam int F_CARRY = 1;
   localparam int F_OVF = 2;
   localparam int F_DZ = 3;
   localparam int F_ILL = 4;

   logic [0:0]       state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;     // MUL: partial product high / DIVU: remainder
   logic [WIDTH-1:0] lo_q, lo_d;     // MUL: multiplier/product low / DIVU: dividend/quotient
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic [4:0]       flags_q, flags_d;
   logic             done_q, done_d;

   // One MUL or DIVU iteration on the {hi, lo} working pair.
   function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] hi,
                                               input logic [WIDTH-1:0] lo,
                                               input logic [WIDTH-1:0] b,
                                               input logic is_div);
      logic [WIDTH:0]     acc;
      logic [WIDTH:0]     trial;
      logic [2*WIDTH-1:0] r;
      if (is_div) begin
         // remainder < divisor always, so the dropped acc MSB only matters when trial succeeds
         acc   = {hi, lo[WIDTH-1]};
         trial = acc - {1'b0, b};
         if (!trial[WIDTH]) r = {trial[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
         else               r = {acc[WIDTH-1:0],   lo[WIDTH-2:0], 1'b0};
      end else begin
         acc = lo[0] ? ({1'b0, hi} + {1'b0, b}) : {1'b0, hi};
         r   = {acc, lo[WIDTH-1:1]};
      end
      return r;
   endfunction

   logic             accept;
   logic             is_multi;
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   sum_w, diff_w;
   logic [WIDTH-1:0] sc_res, sc_hi;
   logic [4:0]       sc_flags;
   logic [2*WIDTH-1:0] nxt;

   assign accept = (state_q == S_IDLE) && bus.start;
   assign shamt  = bus.reg2[SHW-1:0];
   assign sum_w  = {1'b0, bus.reg1} + {1'b0, bus.reg2};
   assign diff_w = {1'b0, bus.reg1} - {1'b0, bus.reg2};

   // Single-cycle result and flags from the live request operands.
   always_comb begin
      sc_res   = '0;
      sc_hi    = '0;
      sc_flags = '0;
      is_multi = 1'b0;
      case (bus.op)
         OP_ADD: begin
            sc_res          = sum_w[WIDTH-1:0];
            sc_flags[F_CARRY] = sum_w[WIDTH];
            sc_flags[F_OVF] = (bus.reg1[WIDTH-1] == bus.reg2[WIDTH-1]) &&
                              (sum_w[WIDTH-1] != bus.reg1[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res          = diff_w[WIDTH-1:0];
            sc_flags[F_CARRY] = diff_w[WIDTH];
            sc_flags[F_OVF] = (bus.reg1[WIDTH-1] != bus.reg2[WIDTH-1]) &&
                              (diff_w[WIDTH-1] != bus.reg1[WIDTH-1]);
         end
         OP_AND: sc_res = bus.reg1 & bus.reg2;
         OP_OR:  sc_res = bus.reg1 | bus.reg2;
         OP_XOR: sc_res = bus.reg1 ^ bus.reg2;
         OP_SL:  sc_res = bus.reg1 << shamt;
         OP_SR:  sc_res = bus.reg1 >> shamt;
         OP_SRA: sc_res = WIDTH'($signed(bus.reg1) >>> shamt);
         OP_MUL: is_multi = 1'b1;
         OP_DIVU: begin
            if (bus.reg2 == '0) begin
               sc_res         = '1;
               sc_hi          = bus.reg1;
               sc_flags[F_DZ] = 1'b1;
            end else begin
               is_multi = 1'b1;
            end
         end
         default: sc_flags[F_ILL] = 1'b1;
      endcase
      sc_flags[F_ZERO] = (sc_res == '0);
   end

   // Iteration 0 runs on the accept edge straight from the request operands,
   // so the last iteration lands on the edge when cnt_q reaches WIDTH-2.
   always_comb begin
      if (accept) nxt = step('0, bus.reg1, bus.reg2, bus.op == OP_DIVU);
      else        nxt = step(hi_q, lo_q, b_q, is_div_q);
   end

   // Handshake FSM, iteration bookkeeping and result capture.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_d    = res_q;
      res_hi_d = res_hi_q;
      flags_d  = flags_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (is_multi) begin
                  state_d  = S_BUSY;
                  cnt_d    = '0;
                  is_div_d = (bus.op == OP_DIVU);
                  b_d      = bus.reg2;
                  hi_d     = nxt[2*WIDTH-1:WIDTH];
                  lo_d     = nxt[WIDTH-1:0];
               end else begin
                  res_d    = sc_res;
                  res_hi_d = sc_hi;
                  flags_d  = sc_flags;
                  done_d   = 1'b1;
               end
            end
         end
         default: begin
            hi_d  = nxt[2*WIDTH-1:WIDTH];
            lo_d  = nxt[WIDTH-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SHW'(WIDTH - 2)) begin
               // MUL: {hi,lo} is the product; DIVU: hi=remainder, lo=quotient
               state_d          = S_IDLE;
               cnt_d            = '0;
               res_d            = nxt[WIDTH-1:0];
               res_hi_d         = nxt[2*WIDTH-1:WIDTH];
               flags_d          = '0;
               flags_d[F_ZERO]  = (nxt[WIDTH-1:0] == '0);
               done_d           = 1'b1;
            end
         end
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         res_q    <= '0;
         res_hi_q <= '0;
         flags_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_q    <= res_d;
         res_hi_q <= res_hi_d;
         flags_q  <= flags_d;
         done_q   <= done_d;
      end
   end

   assign bus.ready       = (state_q == S_IDLE);
   assign bus.done        = done_q;
   assign bus.regOut      = res_q;
   assign bus.regOutHi    = res_hi_q;
   assign bus.flagZero    = flags_q[F_ZERO];
   assign bus.flagCarry   = flags_q[F_CARRY];
   assign bus.flagOvf     = flags_q[F_OVF];
   assign bus.flagDivZero = flags_q[F_DZ];
   assign bus.flagIllegal = flags_q[F_ILL];
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed plan items plus random ops against an arithmetic model.
module tb_seq_alu;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   miscompares = 0;

   seq_alu_if #(.WIDTH(16), .OP_WIDTH(4)) bus ();
   seq_alu #(.WIDTH(16), .OP_WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Spec-level model: f = {illegal, divzero, ovf, carry, zero}
   function automatic void model(input int op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic [15:0] h,
                                 output logic [4:0] f, output bit multi);
      int sa, sb, t;
      longint p;
      logic [3:0] amt;
      sa = int'($signed(a));
      sb = int'($signed(b));
      amt = b[3:0];
      r = '0; h = '0; f = '0; multi = 0;
      case (op)
         0: begin
            t = int'(a) + int'(b);
            r = t[15:0]; f[1] = t[16];
            f[2] = (sa + sb > 32767) || (sa + sb < -32768);
         end
         1: begin
            r = a - b; f[1] = (a < b);
            f[2] = (sa - sb > 32767) || (sa - sb < -32768);
         end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = a << amt;
         6: r = a >> amt;
         7: begin t = sa >>> amt; r = t[15:0]; end
         8: begin p = longint'(a) * longint'(b); r = p[15:0]; h = p[31:16]; multi = 1; end
         9: begin
            if (b == 0) begin r = 16'hFFFF; h = a; f[3] = 1'b1; end
            else begin r = a / b; h = a % b; multi = 1; end
         end
         default: f[4] = 1'b1;
      endcase
      f[0] = (r == 0);
   endfunction

   function automatic logic [36:0] outs();
      return {bus.regOut, bus.regOutHi, bus.flagIllegal, bus.flagDivZero,
              bus.flagOvf, bus.flagCarry, bus.flagZero};
   endfunction

   // Issue one op, watch 20 cycles: latency, ready-low cycles, done count, result.
   task automatic run_op(input string tag, input int op, input logic [15:0] a,
                         input logic [15:0] b, input bit poke);
      logic [15:0] r, h;
      logic [4:0]  f;
      bit          multi;
      logic [36:0] got;
      int lat, rlow, nd;
      model(op, a, b, r, h, f, multi);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 4'(op); bus.reg1 = a; bus.reg2 = b;
      lat = 0; rlow = 0; nd = 0; got = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (!bus.ready) rlow++;
         if (bus.done) begin
            nd++;
            if (lat == 0) begin lat = k; got = outs(); end
         end
         if (k == 1) bus.start = 1'b0;
         if (poke && k == 5) begin
            bus.start = 1'b1; bus.op = 4'd0; bus.reg1 = 16'($urandom); bus.reg2 = 16'($urandom);
         end
         if (poke && k == 6) bus.start = 1'b0;
      end
      check({tag, ":latency"}, 64'(lat), multi ? 64'd16 : 64'd1);
      check({tag, ":ready_low"}, 64'(rlow), multi ? 64'd15 : 64'd0);
      check({tag, ":done_cnt"}, 64'(nd), 64'd1);
      check({tag, ":result"}, 64'(got), 64'({r, h, f}));
   endtask

   // Issue op on this cycle and check the done/result in the following one.
   task automatic b2b_step(input string tag, input int op, input logic [15:0] a, input logic [15:0] b,
                           input logic [36:0] prev_exp, input bit chk_prev);
      bus.start = 1'b1; bus.op = 4'(op); bus.reg1 = a; bus.reg2 = b;
      if (chk_prev) check({tag, ":prev"}, 64'({bus.done, outs()}), 64'({1'b1, prev_exp}));
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] r, h, a, b;
      logic [4:0]  f;
      bit          multi;
      logic [36:0] e_add, e_xor, e_ill;
      int          op;
      bus.start = 1'b0; bus.op = '0; bus.reg1 = '0; bus.reg2 = '0;

      // async reset without a clock edge
      #2 rst_n = 1'b0;
      #1 check("reset", 64'({bus.ready, bus.done, outs()}), 64'({1'b1, 1'b0, 37'd0}));
      @(negedge clk); rst_n = 1'b1;

      run_op("add_2_3",    0, 16'd2,     16'd3,     0);
      run_op("add_carry",  0, 16'hFFFF,  16'h0001,  0);
      run_op("add_ovf",    0, 16'h7FFF,  16'h0001,  0);
      run_op("sub_borrow", 1, 16'd3,     16'd5,     0);
      run_op("sub_ovf",    1, 16'h8000,  16'h0001,  0);
      run_op("sl_amt5",    5, 16'h0002,  16'h0015,  0);
      run_op("sra_15",     7, 16'h8000,  16'd15,    0);
      run_op("sr_15",      6, 16'h8000,  16'd15,    0);
      run_op("mul_poke",   8, 16'h1234,  16'h5678,  1);
      run_op("mul_max",    8, 16'hFFFF,  16'hFFFF,  0);
      run_op("divu_100_7", 9, 16'd100,   16'd7,     0);
      run_op("divu_max",   9, 16'hFFFF,  16'h0001,  0);
      run_op("divu_zero",  9, 16'h1234,  16'h0000,  0);
      run_op("illegal_15", 15, 16'h00AA, 16'h0055,  0);

      // back-to-back single-cycle issue: ADD, XOR, opcode 12
      model(0, 16'h1111, 16'h2222, r, h, f, multi);  e_add = {r, h, f};
      model(4, 16'hF0F0, 16'h0FF0, r, h, f, multi);  e_xor = {r, h, f};
      model(12, 16'h1234, 16'h5678, r, h, f, multi); e_ill = {r, h, f};
      @(negedge clk);
      b2b_step("b2b_add", 0, 16'h1111, 16'h2222, '0, 0);
      b2b_step("b2b_xor", 4, 16'hF0F0, 16'h0FF0, e_add, 1);
      b2b_step("b2b_ill", 12, 16'h1234, 16'h5678, e_xor, 1);
      bus.start = 1'b0;
      check("b2b_ill:prev", 64'({bus.done, outs()}), 64'({1'b1, e_ill}));
      @(negedge clk);
      check("b2b_done_drop", 64'(bus.done), 64'd0);

      // MUL abandoned by reset at iteration 8
      @(negedge clk);
      bus.start = 1'b1; bus.op = 4'd8; bus.reg1 = 16'h1234; bus.reg2 = 16'h5678;
      @(negedge clk); bus.start = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("mul_reset", 64'({bus.ready, bus.done, outs()}), 64'({1'b1, 1'b0, 37'd0}));
      @(negedge clk); rst_n = 1'b1;
      begin
         int nd = 0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done || !bus.ready) nd++;
         end
         check("mul_reset_no_done", 64'(nd), 64'd0);
      end

      // randomized ops against the model
      for (int i = 0; i < 40; i++) begin
         op = int'($urandom_range(0, 11));
         a  = 16'($urandom);
         b  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
         run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
      $finish;
   end
endmodule
